shift_cmd_queue: RTL and testbench

Buffered command front-end for the 32-bit barrel shifter. Accepts shift commands (operand, amount, direction) over a valid/ready handshake and holds them in a small FIFO. It instantiates `SHIFT32` (ports `Y`, `D`, `shift`, `LnR`) on the FIFO head and registers each result into a valid/ready output stage with a zero flag. It sits between the operand/decode logic and the ALU result mux, so that shift operations can be issued back-to-back under downstream backpressure.

---
 rtl/shift_cmd_queue.sv | 123 ++++++++++++
 tb/tb_shift_cmd_queue.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/shift_cmd_queue.sv
// Buffered command front-end for the 32-bit barrel shifter: FIFO of shift commands feeding a registered result stage.
// Optional macro SHIFT_SAT_EN forces a zero result for shift amounts of 32 or more.

module SHIFT32 (
    output logic [31:0] Y,
    input  logic [31:0] D,
    input  logic [31:0] shift,
    input  logic        LnR
);
    // Logical shift over the full 32-bit amount; amounts of 32 or more yield zero
    always_comb begin
        Y = LnR ? (D << shift) : (D >> shift);
    end
endmodule

module shift_cmd_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_data,
    input  logic [31:0]                in_shift,
    input  logic                       in_lnr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_data,
    output logic                       out_zero,
    output logic [$clog2(DEPTH):0]     level,
    output logic [CNT_W-1:0]           done_cnt
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [31:0]   mem_d     [DEPTH];
    logic [31:0]   mem_shift [DEPTH];
    logic          mem_lnr   [DEPTH];

    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic          full;
    logic          empty;
    logic          push;
    logic          load;
    logic          pop;

    logic [31:0]   head_d;
    logic [31:0]   head_shift;
    logic          head_lnr;
    logic [31:0]   y;
    logic [31:0]   res;

    // Extra pointer MSB distinguishes full from empty when the index bits match
    always_comb begin
        full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
        empty    = (wptr == rptr);
        in_ready = !full;
        level    = wptr - rptr;
        push     = in_valid && !full;
        load     = !empty && (!out_valid || out_ready);
        pop      = out_valid && out_ready;
    end

    always_comb begin
        head_d     = mem_d[rptr[AW-1:0]];
        head_shift = mem_shift[rptr[AW-1:0]];
        head_lnr   = mem_lnr[rptr[AW-1:0]];
    end

    SHIFT32 u_shift (
        .Y     (y),
        .D     (head_d),
        .shift (head_shift),
        .LnR   (head_lnr)
    );

`ifdef SHIFT_SAT_EN
    always_comb begin
        res = (head_shift[31:5] != 27'd0) ? 32'd0 : y;
    end
`else
    always_comb begin
        res = y;
    end
`endif

    // Storage array carries no reset; only pointers define valid contents
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_d[wptr[AW-1:0]]     <= in_data;
            mem_shift[wptr[AW-1:0]] <= in_shift;
            mem_lnr[wptr[AW-1:0]]   <= in_lnr;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wptr      <= '0;
            rptr      <= '0;
            out_valid <= 1'b0;
            out_data  <= 32'd0;
            out_zero  <= 1'b1;
            done_cnt  <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + PW'(1);
            end
            if (load) begin
                rptr      <= rptr + PW'(1);
                out_data  <= res;
                out_zero  <= (res == 32'd0);
                out_valid <= 1'b1;
            end else if (pop) begin
                out_valid <= 1'b0;
            end
            if (pop) begin
                done_cnt <= done_cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_shift_cmd_queue.sv
// Directed self-checking bench for shift_cmd_queue (DEPTH=4, CNT_W=16).

module tb_shift_cmd_queue;
    logic        CLK;
    logic        RST;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [31:0] in_shift;
    logic        in_lnr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_zero;
    logic [2:0]  level;
    logic [15:0] done_cnt;

    int checks;
    int failures;

    shift_cmd_queue #(.DEPTH(4), .CNT_W(16)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shift  (in_shift),
        .in_lnr    (in_lnr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_zero  (out_zero),
        .level     (level),
        .done_cnt  (done_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic [31:0] s, input logic l);
        in_valid = v;
        in_data  = d;
        in_shift = s;
        in_lnr   = l;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [31:0] d, input logic z);
        chk({tag, "_valid"}, 32'(out_valid), 32'(v));
        chk({tag, "_data"},  out_data, d);
        chk({tag, "_zero"},  32'(out_zero), 32'(z));
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        RST       = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 1'b0);
        tick();
        tick();
        chk_out("rst", 1'b0, 32'd0, 1'b1);
        chk("rst_done", 32'(done_cnt), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        RST = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Basic right shifts
        out_ready = 1'b1;
        drive(1'b1, 32'd1, 32'd1, 1'b0);
        tick();
        chk("t1_lvl1", 32'(level), 32'd1);
        chk("t1_nolat", 32'(out_valid), 32'd0);
        drive(1'b1, 32'h18, 32'd3, 1'b0);
        tick();
        chk_out("t1_r0", 1'b1, 32'd0, 1'b1);
        drive(1'b0, 32'hDEAD, 32'd0, 1'b1);
        tick();
        chk_out("t1_r1", 1'b1, 32'd3, 1'b0);
        chk("t1_done1", 32'(done_cnt), 32'd1);
        tick();
        chk_out("t1_idle", 1'b0, 32'd3, 1'b0);
        chk("t1_done2", 32'(done_cnt), 32'd2);

        // Left shift, back-to-back
        drive(1'b1, 32'd1, 32'd4, 1'b1);
        tick();
        drive(1'b1, 32'h4, 32'd2, 1'b0);
        tick();
        chk_out("t2_r0", 1'b1, 32'd16, 1'b0);
        drive(1'b0, 32'd0, 32'd0, 1'b0);
        tick();
        chk_out("t2_r1", 1'b1, 32'd1, 1'b0);
        tick();
        chk("t2_idle", 32'(out_valid), 32'd0);
        chk("t2_done", 32'(done_cnt), 32'd4);

        // Backpressure until full
        out_ready = 1'b0;
        drive(1'b1, 32'h100, 32'd2, 1'b0);
        tick();
        chk("t3_lvl_a", 32'(level), 32'd1);
        drive(1'b1, 32'h100, 32'd3, 1'b0);
        tick();
        chk("t3_lvl_b", 32'(level), 32'd1);
        chk_out("t3_head", 1'b1, 32'h40, 1'b0);
        drive(1'b1, 32'h100, 32'd4, 1'b0);
        tick();
        chk("t3_lvl_c", 32'(level), 32'd2);
        drive(1'b1, 32'h100, 32'd5, 1'b0);
        tick();
        chk("t3_lvl_d", 32'(level), 32'd3);
        chk("t3_rdy_d", 32'(in_ready), 32'd1);
        drive(1'b1, 32'h100, 32'd6, 1'b0);
        tick();
        chk("t3_lvl_e", 32'(level), 32'd4);
        chk("t3_full", 32'(in_ready), 32'd0);
        drive(1'b1, 32'h100, 32'd7, 1'b0);
        tick();
        chk("t3_refused", 32'(level), 32'd4);
        chk_out("t3_hold", 1'b1, 32'h40, 1'b0);
        chk("t3_done_hold", 32'(done_cnt), 32'd4);

        // Push offered while full and popping: refused, no pass-through
        out_ready = 1'b1;
        tick();
        chk("t3_fullpop_lvl", 32'(level), 32'd3);
        chk_out("t3_b", 1'b1, 32'h20, 1'b0);
        drive(1'b0, 32'd0, 32'd0, 1'b0);
        tick();
        chk_out("t3_c", 1'b1, 32'h10, 1'b0);
        chk("t3_lvl2", 32'(level), 32'd2);
        // Push and pop together at level 2
        drive(1'b1, 32'h100, 32'd1, 1'b1);
        tick();
        chk("t4_lvl_same", 32'(level), 32'd2);
        chk_out("t4_d", 1'b1, 32'h8, 1'b0);
        drive(1'b0, 32'd0, 32'd0, 1'b0);
        tick();
        chk_out("t4_e", 1'b1, 32'h4, 1'b0);
        tick();
        chk_out("t4_g", 1'b1, 32'h200, 1'b0);
        chk("t4_lvl0", 32'(level), 32'd0);
        tick();
        chk("t4_idle", 32'(out_valid), 32'd0);
        chk("t4_done", 32'(done_cnt), 32'd10);

        // Reset mid-operation with level 3 and a held result
        out_ready = 1'b0;
        drive(1'b1, 32'd5, 32'd0, 1'b1);
        tick();
        drive(1'b1, 32'd6, 32'd0, 1'b1);
        tick();
        drive(1'b1, 32'd7, 32'd0, 1'b1);
        tick();
        drive(1'b1, 32'd8, 32'd0, 1'b1);
        tick();
        drive(1'b0, 32'd0, 32'd0, 1'b0);
        chk("t5_pre_lvl", 32'(level), 32'd3);
        chk_out("t5_pre", 1'b1, 32'd5, 1'b0);
        #1;
        RST = 1'b0;
        #1;
        chk_out("t5_rst", 1'b0, 32'd0, 1'b1);
        chk("t5_rst_lvl", 32'(level), 32'd0);
        chk("t5_rst_done", 32'(done_cnt), 32'd0);
        #1;
        RST = 1'b1;
        out_ready = 1'b1;
        tick();
        tick();
        chk("t5_after_valid", 32'(out_valid), 32'd0);
        chk("t5_after_lvl", 32'(level), 32'd0);
        chk("t5_after_rdy", 32'(in_ready), 32'd1);

        // Amounts of 32 or more
        drive(1'b1, 32'hFFFFFFFF, 32'd32, 1'b1);
        tick();
        drive(1'b1, 32'hFFFFFFFF, 32'd31, 1'b0);
        tick();
        chk_out("t6_sat", 1'b1, 32'd0, 1'b1);
        drive(1'b0, 32'd0, 32'd0, 1'b0);
        tick();
        chk_out("t6_31", 1'b1, 32'd1, 1'b0);
        tick();
        chk("t6_done", 32'(done_cnt), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
